// File: rtl/cache_fill_fsm.sv
// Purpose: cache miss fill controller. It stalls the pipeline, streams BLOCK_WORDS word reads
//          to main memory, writes each returned word into the data array, and then writes the tag.
// Latency: fsm_busy rises combinationally in the miss cycle. Requests go out in cycles 1..BLOCK_WORDS.
//          With memory latency L, the block is back in IDLE in cycle BLOCK_WORDS+L+1.
// Backpressure: none toward memory. One request is issued per cycle, and every memory_data_valid
//               is accepted. The pipeline is held through fsm_busy.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   miss_detected, miss_address     miss strobe and byte address from the cache lookup
//   memory_data_valid               main memory returns one word this cycle
//   fsm_busy                        stall request to the pipeline
//   memory_req, memory_address      word read request and its byte address
//   write_data_array                data-array write strobe (follows memory_data_valid in FILL)
//   fill_word_index                 word offset within the block for the data-array write
//   write_tag_array                 tag/valid write strobe, one pulse on the last word
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           memory_data_valid,
    output logic                           fsm_busy,
    output logic                           memory_req,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_index,
    output logic                           write_tag_array
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    // issue_cnt needs one extra bit so that it can sit at BLOCK_WORDS once all requests are out.
    localparam int CNT_W = IDX_W + 1;
    // A block spans BLOCK_WORDS 16-bit words, which is 2*BLOCK_WORDS bytes.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << (IDX_W + 1)) - 1);
    localparam logic [CNT_W-1:0]  ISSUE_END = CNT_W'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        base_d           = base_q;
        fsm_busy         = 1'b0;
        memory_req       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_index  = '0;
        write_tag_array  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Stall in the miss cycle itself so the pipeline does not advance past the miss.
                // Returning data in IDLE is stale and is dropped.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_d     = FILL;
                    base_d      = miss_address & BASE_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            FILL: begin
                // New misses are ignored here. The cache looks up again once the stall drops.
                fsm_busy = 1'b1;
                if (issue_cnt_q < ISSUE_END) begin
                    memory_req     = 1'b1;
                    memory_address = base_q + ADDR_W'({issue_cnt_q, 1'b0});
                    issue_cnt_d    = issue_cnt_q + CNT_W'(1);
                end
                // Returns are counted independently of issue, so they may overlap request issue.
                // Memory is trusted to return words in order.
                write_data_array = memory_data_valid;
                fill_word_index  = recv_cnt_q;
                if (memory_data_valid) begin
                    recv_cnt_d = recv_cnt_q + IDX_W'(1);
                    if (recv_cnt_q == LAST_IDX) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm. It covers an 8-word instance through basic, back-to-back,
// gapped, ignored-input and reset-mid-fill scenarios, plus a 4-word instance with one-cycle latency.
// Inputs are driven on the falling edge, and outputs are checked 1 ns later.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy, memory_req, write_data_array, write_tag_array;
    logic [15:0] memory_address;
    logic [2:0]  fill_word_index;

    logic        m4_miss = 1'b0;
    logic [15:0] m4_addr = 16'h0;
    logic        m4_vld = 1'b0;
    logic        b4_busy, b4_req, b4_wr, b4_tag;
    logic [15:0] b4_maddr;
    logic [1:0]  b4_idx;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_req        (memory_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_index   (fill_word_index),
        .write_tag_array   (write_tag_array)
    );

    cache_fill_fsm #(.BLOCK_WORDS(4), .ADDR_W(16)) dut4 (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (m4_miss),
        .miss_address      (m4_addr),
        .memory_data_valid (m4_vld),
        .fsm_busy          (b4_busy),
        .memory_req        (b4_req),
        .memory_address    (b4_maddr),
        .write_data_array  (b4_wr),
        .fill_word_index   (b4_idx),
        .write_tag_array   (b4_tag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic e_busy);
        chk({tag, "_busy"}, 32'(fsm_busy), 32'(e_busy));
        chk({tag, "_req"},  32'(memory_req), 0);
        chk({tag, "_addr"}, 32'(memory_address), 0);
        chk({tag, "_wr"},   32'(write_data_array), 0);
        chk({tag, "_idx"},  32'(fill_word_index), 0);
        chk({tag, "_tag"},  32'(write_tag_array), 0);
    endtask

    // One 8-word fill. The miss is in cycle 0, and words return at first, first+stride, and so on.
    // A stray miss with a different address is injected in cycle 3 and in the tag cycle. It must
    // not disturb the fill. stop >= 0 ends the run early, after that cycle.
    task automatic fill8(input logic [15:0] maddr, input logic [15:0] base, input int first,
                         input int stride, input int stop, input string tag);
        int   last;
        int   run_to;
        int   k;
        logic vld;
        logic in_req;
        last   = first + 7 * stride;
        run_to = (stop >= 0) ? stop : last;
        for (int c = 0; c <= run_to; c++) begin
            vld    = (c >= first) && (c <= last) && (((c - first) % stride) == 0);
            k      = (c - first) / stride;
            in_req = (c >= 1) && (c <= 8);
            @(negedge clk);
            miss_detected     = (c == 0) || (c == 3) || (c == last);
            miss_address      = (c == 0) ? maddr : 16'h7770;
            memory_data_valid = vld;
            #1;
            chk({tag, "_busy"}, 32'(fsm_busy), 1);
            chk({tag, "_req"},  32'(memory_req), 32'(in_req));
            chk({tag, "_addr"}, 32'(memory_address),
                in_req ? 32'(base) + 32'(2 * (c - 1)) : 0);
            chk({tag, "_wr"},   32'(write_data_array), 32'(vld));
            if (vld) chk({tag, "_idx"}, 32'(fill_word_index), 32'(k));
            chk({tag, "_tag"},  32'(write_tag_array), 32'(c == last));
        end
    endtask

    task automatic idle_cyc(input logic vld, input string tag);
        @(negedge clk);
        miss_detected     = 1'b0;
        miss_address      = 16'h5552;
        memory_data_valid = vld;
        #1;
        chk_quiet(tag, 1'b0);
    endtask

    initial begin
        // The block is in reset with quiet inputs. Then a miss is raised while still in reset,
        // and busy must follow the IDLE equation.
        #2;
        chk_quiet("rst", 1'b0);
        miss_detected = 1'b1;
        #1;
        chk_quiet("rst_miss", 1'b1);
        miss_detected = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic fill with L=4, immediately followed by a back-to-back fill with L=1.
        fill8(16'h1236, 16'h1230, 5, 1, -1, "basic");
        fill8(16'h4000, 16'h4000, 2, 1, -1, "b2b");
        // Back in IDLE: stray valids must neither write nor advance the counter.
        idle_cyc(1'b0, "b2b_idle");
        idle_cyc(1'b1, "idle_vld0");
        idle_cyc(1'b1, "idle_vld1");

        // Gapped returns in cycles 5, 7, ..., 19. Busy must fall in cycle 20.
        fill8(16'h2004, 16'h2000, 5, 2, -1, "gap");
        idle_cyc(1'b0, "gap_end");

        // Reset after the third returned word, which arrives in cycle 7.
        fill8(16'h1236, 16'h1230, 5, 1, 7, "pre_rst");
        @(negedge clk);
        memory_data_valid = 1'b1;
        rst_n             = 1'b0;
        #1;
        chk_quiet("mid_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cyc(1'b1, "late_vld0");
        idle_cyc(1'b1, "late_vld1");
        idle_cyc(1'b1, "late_vld2");
        fill8(16'h00F0, 16'h00F0, 5, 1, -1, "post_rst");
        idle_cyc(1'b0, "post_rst_end");

        // 4-word instance with L=1: miss 0x0009 gives base 0x0008.
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            m4_miss = (c == 0);
            m4_addr = (c == 0) ? 16'h0009 : 16'h0;
            m4_vld  = (c >= 2) && (c <= 5);
            #1;
            chk("bw4_busy", 32'(b4_busy), 32'(c <= 5));
            chk("bw4_req",  32'(b4_req), 32'((c >= 1) && (c <= 4)));
            chk("bw4_addr", 32'(b4_maddr),
                ((c >= 1) && (c <= 4)) ? 32'(8 + 2 * (c - 1)) : 0);
            chk("bw4_wr",   32'(b4_wr), 32'(m4_vld));
            if (m4_vld) chk("bw4_idx", 32'(b4_idx), 32'(c - 2));
            chk("bw4_tag",  32'(b4_tag), 32'(c == 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits between the L1 caches and the pipelined CPU. On a cache miss it stalls the pipeline and fetches the full block from a multi-cycle, pipelined main memory. It issues one word request per cycle and writes each returning word into the cache data array. When the last word arrives, it writes the tag array and releases the stall. One instance serves the instruction cache and one serves the data cache; arbitration between them is outside this block.

## Interface

**Parameters**
- `BLOCK_WORDS`, default 8: 16-bit words per cache block. Must be a power of two, 2..16.
- `ADDR_W`, default 16: byte-address width.

**Ports**
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `miss_detected`  in  1  cache lookup missed this cycle.
- `miss_address`  in  ADDR_W  byte address of the missing access.
- `memory_data_valid`  in  1  main memory returns one word this cycle.
- `fsm_busy`  out  1  stall request to the pipeline.
- `memory_req`  out  1  read request to main memory.
- `memory_address`  out  ADDR_W  byte address of the requested word.
- `write_data_array`  out  1  write the returning word into the data array.
- `fill_word_index`  out  log2(BLOCK_WORDS)  word offset for the data-array write.
- `write_tag_array`  out  1  write tag and valid for the block.

## Operation

**States:** IDLE, FILL.

**Transitions**
- IDLE → FILL: on a rising edge with `miss_detected`=1.
- FILL → IDLE: on the rising edge that ends the cycle in which the BLOCK_WORDS-th valid word is received.

**Entry into FILL**
- Latch the block base: `miss_address` with the low log2(BLOCK_WORDS)+1 bits cleared.
- Clear both counters: `issue_cnt` and `recv_cnt`.

**Request issue (FILL)**
- `memory_req`=1 while `issue_cnt` < BLOCK_WORDS.
- `memory_address` = base + 2·`issue_cnt`.
- `issue_cnt` increments each cycle while `memory_req`=1, then holds at BLOCK_WORDS.
- When `memory_req`=0, `memory_address` = 0.

**Data return (FILL)**
- `write_data_array` = `memory_data_valid`, combinationally.
- `fill_word_index` = `recv_cnt`.
- `recv_cnt` increments on each valid.
- `write_tag_array`=1 in the same cycle as the valid with `recv_cnt` = BLOCK_WORDS−1.

**Stall**
- `fsm_busy` = (state==FILL) | (state==IDLE & `miss_detected`). The combinational term stalls the pipeline in the miss cycle itself.

**Ignored inputs**
- `miss_detected` during FILL is ignored. This includes the `write_tag_array` cycle; the cache re-looks up after the stall drops.
- `memory_data_valid` in IDLE is ignored: no writes, no counter change.
- Changes to `miss_address` after entry have no effect, because the base is latched.

**Memory handling**
- Data may return while requests are still being issued. The counters are independent, so returns may overlap issue.
- The block trusts memory to return exactly one word per request, in order. Memory latency is not modelled internally.

**Reset**
- Asserting `rst_n`=0, including mid-fill, forces IDLE immediately and clears both counters and the base.
- All outputs go to 0 except `fsm_busy`, which follows its IDLE equation.
- Valid words arriving after a reset are ignored.

## Timing

- Reset values: state IDLE; `memory_req`=0, `memory_address`=0, `write_data_array`=0, `fill_word_index`=0, `write_tag_array`=0. `fsm_busy`=`miss_detected` (0 with quiet inputs).
- The miss is seen in cycle 0. Requests are issued in cycles 1..BLOCK_WORDS, on consecutive cycles with no gaps.
- With a memory latency of L cycles, data returns in cycles 1+L..BLOCK_WORDS+L. `write_tag_array` pulses in cycle BLOCK_WORDS+L, and the block is in IDLE in cycle BLOCK_WORDS+L+1.
- `fsm_busy` is high in cycles 0..BLOCK_WORDS+L inclusive.
- Back-to-back fills: a miss in the first IDLE cycle re-enters FILL on the next edge, with no dead cycle beyond that IDLE cycle.
- `write_tag_array` is a single-cycle pulse per fill, and is never asserted outside FILL.

## Test plan

- Basic fill, L=4: set `miss_address`=0x1236 → base 0x1230. Expect `memory_req` in cycles 1..8 with addresses 0x1230, 0x1232, …, 0x123E. Expect `write_data_array` in cycles 5..12 with index 0..7, `write_tag_array` only in cycle 12, and `fsm_busy` high in cycles 0..12.
- Gapped returns: valid words arrive in cycles 5, 7, 9, …, 19. Expect 8 writes with indices 0..7 in order, `write_tag_array` in cycle 19, and `fsm_busy` falling in cycle 20.
- Ignored inputs: pulse `miss_detected` with a new address during FILL, and pulse `memory_data_valid` in IDLE. Expect no address change, no restart, and no writes or counter change in IDLE.
- Reset mid-fill: assert `rst_n` low after the 3rd returned word. Expect all outputs 0 immediately. Late valid words after release produce no writes; a new miss at 0x00F0 fills cleanly with indices starting at 0.
- Back-to-back fills: raise a second miss at 0x4000 in the first IDLE cycle after a fill. Expect FILL re-entry on the next edge, with requests 0x4000..0x400E.
- Parameter check, `BLOCK_WORDS`=4, L=1: set `miss_address`=0x0009 → base 0x0008. Expect requests 0x0008..0x000E in cycles 1..4, writes in cycles 2..5, and `write_tag_array` in cycle 5.
